cp0_exception_unit: RTL

- Coprocessor-0 block and the receiving end of the pipeline's exception signals.
- Collects exception codes from the stages, including E-stage ALU arithmetic overflow (Ov) and address-calculation overflow (AdEL/AdES), plus external hardware interrupts.
- Decides whether to take a trap and records SR/Cause/EPC state.
- Serves mfc0/mtc0/eret; sits at the M stage, and its Req output flushes the pipeline and redirects the PC to the handler.

---
 rtl/cp0_exception_unit_if.sv | 25 ++
 rtl/cp0_exception_unit.sv | 73 +++++++
 2 files changed

// File: rtl/cp0_exception_unit_if.sv
// Pipeline-to-CP0 bundle: mfc0/mtc0 access, M-stage victim info, interrupts and trap outputs.
interface cp0_exception_unit_if;
  logic        en;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_in;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        exl_clr;
  logic [31:0] cp0_out;
  logic [31:0] epc_out;
  logic        req;
  logic [31:0] handler_pc;

  modport master (
    output en, cp0_addr, cp0_in, vpc, bd_in, exc_code_in, hw_int, exl_clr,
    input  cp0_out, epc_out, req, handler_pc
  );

  modport slave (
    input  en, cp0_addr, cp0_in, vpc, bd_in, exc_code_in, hw_int, exl_clr,
    output cp0_out, epc_out, req, handler_pc
  );
endinterface

// File: rtl/cp0_exception_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId, trap decision at the M stage, mfc0/mtc0/eret service.
module cp0_exception_unit #(
  parameter logic [31:0] PRID_VALUE = 32'h0000_0000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic                 clk,
  input  logic                 reset,
  cp0_exception_unit_if.slave  bus
);

  localparam logic [31:0] SR_MASK = 32'h0000_FC03;

  // Registers held as full words; unimplemented bits are constant zero.
  logic [31:0] sr_q, sr_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] vpc_aligned;
  logic        int_req, exc_req, req;

  always_comb begin
    int_req     = (|(bus.hw_int & sr_q[15:10])) & sr_q[0] & ~sr_q[1];
    exc_req     = (bus.exc_code_in != '0) & ~sr_q[1];
    req         = int_req | exc_req;
    vpc_aligned = bus.vpc & ~32'd3;

    sr_d    = sr_q;
    cause_d = {cause_q[31], 15'b0, bus.hw_int, 3'b0, cause_q[6:2], 2'b0};
    epc_d   = epc_q;

    if (req) begin
      sr_d[1]       = 1'b1;
      cause_d[31]   = bus.bd_in;
      cause_d[6:2]  = int_req ? 5'd0 : bus.exc_code_in;
      epc_d         = bus.bd_in ? vpc_aligned - 32'd4 : vpc_aligned;
    end else begin
      if (bus.en && bus.cp0_addr == 5'd12)
        sr_d = bus.cp0_in & SR_MASK;
      if (bus.en && bus.cp0_addr == 5'd14)
        epc_d = bus.cp0_in & ~32'd3;
      // eret applies after the mtc0 so a same-edge SR write cannot keep EXL set
      if (bus.exl_clr)
        sr_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q    <= '0;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      sr_q    <= sr_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  always_comb begin
    bus.cp0_out = '0;
    case (bus.cp0_addr)
      5'd12:   bus.cp0_out = sr_q;
      5'd13:   bus.cp0_out = cause_q;
      5'd14:   bus.cp0_out = epc_q;
      5'd15:   bus.cp0_out = PRID_VALUE;
      default: bus.cp0_out = '0;
    endcase
  end

  assign bus.epc_out    = epc_q;
  assign bus.req        = req;
  assign bus.handler_pc = HANDLER_PC;

endmodule
